// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Also detects load-use hazards, inserts bubbles and drives the PC / IF/ID freeze.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic [4:0]        if_id_rs_i,
  input  logic [4:0]        if_id_rt_i,
  input  logic [4:0]        if_id_rd_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [DATA_W-1:0] pc_plus4_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [4:0]        id_ex_rs_o,
  output logic [4:0]        id_ex_rt_o,
  output logic [4:0]        id_ex_rd_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [DATA_W-1:0] pc_plus4_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              valid_o,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int MEM_READ_BIT = 1;

  logic [4:0]        rs_q, rs_d;
  logic [4:0]        rt_q, rt_d;
  logic [4:0]        rd_q, rd_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] pc_plus4_q, pc_plus4_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic cnt_max;

  // A load in EX whose destination is read by the instruction in ID; $0 never counts.
  assign load_use = valid_q & ctrl_q[MEM_READ_BIT] & (rt_q != 5'd0) &
                    ((rt_q == if_id_rs_i) | (rt_q == if_id_rt_i));

  assign pc_write_o    = ~(load_use | hold_i);
  assign if_id_write_o = ~(load_use | hold_i);
  assign cnt_max       = (stall_cnt_q == {CNT_W{1'b1}});

  always_comb begin
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    pc_plus4_d  = pc_plus4_q;
    ctrl_d      = ctrl_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;

    if (flush_i || !hold_i) begin
      rs_d       = if_id_rs_i;
      rt_d       = if_id_rt_i;
      rd_d       = if_id_rd_i;
      rs_data_d  = rs_data_i;
      rt_data_d  = rt_data_i;
      imm_d      = imm_i;
      pc_plus4_d = pc_plus4_i;
    end

    // Squash beats freeze, freeze beats bubble; only real bubbles are counted.
    if (flush_i) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else if (hold_i) begin
      ctrl_d  = ctrl_q;
      valid_d = valid_q;
    end else if (load_use) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
      if (!cnt_max) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else begin
      ctrl_d  = ctrl_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      pc_plus4_q  <= '0;
      ctrl_q      <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      pc_plus4_q  <= pc_plus4_d;
      ctrl_q      <= ctrl_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign id_ex_rs_o  = rs_q;
  assign id_ex_rt_o  = rt_q;
  assign id_ex_rd_o  = rd_q;
  assign rs_data_o   = rs_data_q;
  assign rt_data_o   = rt_data_q;
  assign imm_o       = imm_q;
  assign pc_plus4_o  = pc_plus4_q;
  assign ctrl_o      = ctrl_q;
  assign valid_o     = valid_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
